tensor_iter_agu: RTL and testbench
==================================

TENSOR_ITER_AGU -- requirements
Module: tensor_iter_agu

Interface
REQ-001 SHALL have parameter NDIM, default 4, number of tensor dimensions (row-major, dim NDIM-1 fastest).
REQ-002 SHALL have parameter DIM_W, default 16, width of each shape/index field.
REQ-003 SHALL have parameter ADDR_W, default 32, width of offsets and strides (two's complement).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1, configuration/start request.
REQ-007 SHALL have port cfg_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port cfg_shape, input, NDIM*DIM_W, unsigned extent per dim.
REQ-009 SHALL have port cfg_strides, input, NDIM*ADDR_W, signed element stride per dim.
REQ-010 SHALL have port cfg_base, input, ADDR_W, offset of element [0,...,0].
REQ-011 SHALL have port abort, input, 1, synchronous cancel of the current walk.
REQ-012 SHALL have port out_valid, output, 1, element descriptor valid.
REQ-013 SHALL have port out_ready, input, 1, downstream write stage accepts the descriptor.
REQ-014 SHALL have port out_offset, output, ADDR_W, storage offset of the current element.
REQ-015 SHALL have port out_index, output, NDIM*DIM_W, multidimensional index of the current element.
REQ-016 SHALL have port out_nth, output, 32, linear element number, starting at 0.
REQ-017 SHALL have port out_last, output, 1, current element is the final one.
REQ-018 SHALL have port done, output, 1, one-cycle pulse when a walk ends (completion, empty shape or abort).

Function
REQ-019 SHALL implement FSM IDLE, RUN; transfer on cfg_valid&&cfg_ready.
REQ-020 SHALL, on transfer, register shape, strides and base, and precompute backstride[k]=(shape[k]-1)*stride[k] mod 2^ADDR_W.
REQ-021 SHALL, on transfer with any shape[k]==0, stay in IDLE, pulse done next cycle and emit no descriptor.
REQ-022 SHALL otherwise enter RUN with out_valid=1 the cycle after transfer, with out_offset=base, out_index=0 and out_nth=0.
REQ-023 SHALL advance only on out_valid&&out_ready: index[NDIM-1] increments; a dim at shape[k]-1 wraps to 0 and carries to dim k-1.
REQ-024 SHALL update the offset incrementally: +stride[k] at the lowest non-wrapping dim k, and -backstride[j] for every wrapped dim j; no multipliers in the per-element path.
REQ-025 SHALL use modulo 2^ADDR_W offset arithmetic with no overflow flag.
REQ-026 SHALL increment out_nth by 1 per accepted element.
REQ-027 SHALL assert out_last when every index[k]==shape[k]-1; this includes a 1-element tensor on its first descriptor.
REQ-028 SHALL, on acceptance of the out_last element, drop out_valid, return to IDLE and pulse done in the same cycle as the return to IDLE.
REQ-029 SHALL hold all out_* stable while out_valid&&!out_ready.
REQ-030 SHALL, on abort in RUN, deassert out_valid next cycle, return to IDLE and pulse done; abort has priority over a simultaneous handshake.
REQ-031 SHALL ignore abort in IDLE.
REQ-032 SHALL sustain one descriptor per cycle with out_ready held high.
REQ-033 SHALL NOT depend combinationally on out_ready for out_valid or any out_* field.

Reset
REQ-034 SHALL on rst_n low: state=IDLE; out_valid, out_last, done=0; out_offset, out_index, out_nth=0; cfg_ready=1 after release.
REQ-035 SHALL treat reset mid-walk as discard; no done pulse is generated for the interrupted walk.

Structure
REQ-036 SHALL take NDIM, DIM_W, ADDR_W defaults and the FSM state enum from shared package tensor_pkg.
REQ-037 SHALL instantiate NDIM copies of sub-module tensor_dim_counter (index register, wrap detect, carry in/out).

Verification
REQ-038 SHALL test shape [2,3], strides [3,1], base 0, out_ready=1: offsets 0,1,2,3,4,5, last on nth=5, done one cycle later.
REQ-039 SHALL test transposed shape [2,3], strides [1,2], base 100: offsets 100,102,104,101,103,105.
REQ-040 SHALL test negative stride, shape [4], stride -1, base 3: offsets 3,2,1,0.
REQ-041 SHALL test shape [3,0]: cfg accepted, no out_valid, done pulse, cfg_ready stays 1.
REQ-042 SHALL test random out_ready stalls on shape [2,2,2]: fields stable during stalls, 8 descriptors, in-order nth 0..7.
REQ-043 SHALL test abort asserted with out_valid&&out_ready at nth=2 of 6: nth=2 not counted as accepted, IDLE next cycle, done pulse; a following cfg restarts at nth=0.

Source files
------------

// File: rtl/tensor_pkg.sv
// Shared defaults and FSM state type for the tensor iteration address generator.
package tensor_pkg;

    localparam int TENSOR_NDIM   = 4;
    localparam int TENSOR_DIM_W  = 16;
    localparam int TENSOR_ADDR_W = 32;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } agu_state_e;

endpackage

// File: rtl/tensor_iter_agu_if.sv
// Configuration, descriptor stream and status bundle of the tensor AGU.
interface tensor_iter_agu_if
    import tensor_pkg::*;
#(
    parameter int NDIM   = TENSOR_NDIM,
    parameter int DIM_W  = TENSOR_DIM_W,
    parameter int ADDR_W = TENSOR_ADDR_W
);

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [NDIM*DIM_W-1:0]    cfg_shape;
    logic [NDIM*ADDR_W-1:0]   cfg_strides;
    logic [ADDR_W-1:0]        cfg_base;
    logic                     abort;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_offset;
    logic [NDIM*DIM_W-1:0]    out_index;
    logic [31:0]              out_nth;
    logic                     out_last;
    logic                     done;

    // master issues walks and consumes descriptors; slave is the AGU itself
    modport master (
        output cfg_valid, cfg_shape, cfg_strides, cfg_base, abort, out_ready,
        input  cfg_ready, out_valid, out_offset, out_index, out_nth, out_last, done
    );

    modport slave (
        input  cfg_valid, cfg_shape, cfg_strides, cfg_base, abort, out_ready,
        output cfg_ready, out_valid, out_offset, out_index, out_nth, out_last, done
    );

endinterface

// File: rtl/tensor_dim_counter.sv
// One dimension of the index odometer: counts on carry_in, wraps at shape-1, carries out on wrap.
module tensor_dim_counter
    import tensor_pkg::*;
#(
    parameter int DIM_W = TENSOR_DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             carry_in,
    input  logic [DIM_W-1:0] shape,
    output logic [DIM_W-1:0] idx,
    output logic             at_max,
    output logic             carry_out
);

    assign at_max    = (idx == shape - DIM_W'(1));
    assign carry_out = carry_in & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (carry_in) begin
            idx <= at_max ? '0 : idx + DIM_W'(1);
        end
    end

endmodule

// File: rtl/tensor_iter_agu.sv
// Walks an NDIM tensor in row-major order, emitting one storage-offset descriptor per element.
module tensor_iter_agu
    import tensor_pkg::*;
#(
    parameter int NDIM   = TENSOR_NDIM,
    parameter int DIM_W  = TENSOR_DIM_W,
    parameter int ADDR_W = TENSOR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    tensor_iter_agu_if.slave  bus
);

    agu_state_e        state;
    logic              valid_q;
    logic              done_q;
    logic [ADDR_W-1:0] offset_q;
    logic [31:0]       nth_q;

    logic [DIM_W-1:0]  shape_q      [NDIM];
    logic [ADDR_W-1:0] stride_q     [NDIM];
    logic [ADDR_W-1:0] backstride_q [NDIM];
    logic [DIM_W-1:0]  idx          [NDIM];

    logic [NDIM-1:0]   carry_in;
    logic [NDIM-1:0]   carry_out;
    logic [NDIM-1:0]   at_max;
    logic              transfer;
    logic              shape_zero;
    logic              advance;
    logic [ADDR_W-1:0] delta;

    assign transfer = bus.cfg_valid && (state == ST_IDLE);
    // abort wins over a simultaneous handshake, so it blocks the advance
    assign advance  = (state == ST_RUN) && valid_q && bus.out_ready && !bus.abort;

    always_comb begin
        // NOTE: default before the loop so no path leaves shape_zero unassigned (no latch).
        shape_zero = 1'b0;
        for (int k = 0; k < NDIM; k++) begin
            if (bus.cfg_shape[k*DIM_W +: DIM_W] == '0) shape_zero = 1'b1;
        end
    end

    // NOTE: configuration registers are read only in RUN, which is reached only through a load, so they carry no reset.
    always_ff @(posedge clk) begin
        if (transfer) begin
            for (int k = 0; k < NDIM; k++) begin
                shape_q[k]      <= bus.cfg_shape[k*DIM_W +: DIM_W];
                stride_q[k]     <= bus.cfg_strides[k*ADDR_W +: ADDR_W];
                backstride_q[k] <= (ADDR_W'(bus.cfg_shape[k*DIM_W +: DIM_W]) - ADDR_W'(1))
                                   * bus.cfg_strides[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // carry ripples from the fastest dim (NDIM-1) toward dim 0
    if (NDIM > 1) begin : g_chain
        assign carry_in = {advance, carry_out[NDIM-1:1]};
    end else begin : g_single
        assign carry_in = advance;
    end

    for (genvar g = 0; g < NDIM; g++) begin : g_dim
        tensor_dim_counter #(.DIM_W(DIM_W)) u_dim (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (transfer),
            .carry_in  (carry_in[g]),
            .shape     (shape_q[g]),
            .idx       (idx[g]),
            .at_max    (at_max[g]),
            .carry_out (carry_out[g])
        );
        assign bus.out_index[g*DIM_W +: DIM_W] = idx[g];
    end

    // stepping dims add their stride; wrapping dims rewind by their backstride
    always_comb begin
        delta = '0;
        for (int k = 0; k < NDIM; k++) begin
            if (carry_in[k]) begin
                delta = at_max[k] ? delta - backstride_q[k] : delta + stride_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            offset_q <= '0;
            nth_q    <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        offset_q <= bus.cfg_base;
                        nth_q    <= '0;
                        if (shape_zero) begin
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (advance) begin
                        offset_q <= offset_q + delta;
                        nth_q    <= nth_q + 32'd1;
                        if (carry_out[0]) begin
                            state   <= ST_IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = (state == ST_IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_offset = offset_q;
    assign bus.out_nth    = nth_q;
    assign bus.out_last   = valid_q & (&at_max);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_tensor_iter_agu.sv
// Randomised and directed bench for tensor_iter_agu against a mixed-radix reference model.
module tb_tensor_iter_agu;
    import tensor_pkg::*;

    localparam int NDIM   = TENSOR_NDIM;
    localparam int DIM_W  = TENSOR_DIM_W;
    localparam int ADDR_W = TENSOR_ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tensor_iter_agu_if bus ();

    tensor_iter_agu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model state, advanced once per cycle by the monitor
    int unsigned m_shape  [NDIM];
    logic [31:0] m_stride [NDIM];
    logic [31:0] m_base;
    int unsigned m_total;
    int unsigned m_nth;
    bit          m_busy = 1'b0;
    bit          m_done_pend = 1'b0;

    logic [31:0] acc_off  [$];
    int unsigned acc_nth  [$];
    int unsigned last_nth [$];
    int          done_cnt = 0;
    bit          rand_ready = 1'b0;

    // element n in row-major order: mixed-radix digits, offset = base + sum(idx*stride)
    function automatic void model_desc(input int unsigned n, output logic [31:0] off,
                                       output logic [63:0] index);
        int unsigned rem;
        int unsigned d;
        rem   = n;
        off   = m_base;
        index = '0;
        for (int k = NDIM - 1; k >= 0; k--) begin
            d   = rem % m_shape[k];
            rem = rem / m_shape[k];
            index[k*DIM_W +: DIM_W] = DIM_W'(d);
            off = off + 32'(d) * m_stride[k];
        end
    endfunction

    always @(negedge clk) begin
        logic [31:0] eo;
        logic [63:0] ei;
        if (rst_n) begin
            check("cfg_ready", 64'(bus.cfg_ready), 64'(!m_busy));
            check("out_valid", 64'(bus.out_valid), 64'(m_busy));
            check("done", 64'(bus.done), 64'(m_done_pend));
            if (bus.done) done_cnt++;
            if (m_busy) begin
                model_desc(m_nth, eo, ei);
                check("out_offset", 64'(bus.out_offset), 64'(eo));
                check("out_index", bus.out_index, ei);
                check("out_nth", 64'(bus.out_nth), 64'(m_nth));
                check("out_last", 64'(bus.out_last), 64'(m_nth == m_total - 1));
            end
            m_done_pend = 1'b0;
            if (m_busy) begin
                if (bus.abort) begin
                    m_busy      = 1'b0;
                    m_done_pend = 1'b1;
                end else if (bus.out_ready) begin
                    acc_off.push_back(bus.out_offset);
                    acc_nth.push_back(bus.out_nth);
                    if (bus.out_last) last_nth.push_back(bus.out_nth);
                    if (m_nth == m_total - 1) begin
                        m_busy      = 1'b0;
                        m_done_pend = 1'b1;
                    end else begin
                        m_nth++;
                    end
                end
            end else if (bus.cfg_valid) begin
                m_total = 1;
                for (int k = 0; k < NDIM; k++) begin
                    m_shape[k]  = bus.cfg_shape[k*DIM_W +: DIM_W];
                    m_stride[k] = bus.cfg_strides[k*ADDR_W +: ADDR_W];
                    m_total     = m_total * m_shape[k];
                end
                m_base = bus.cfg_base;
                m_nth  = 0;
                if (m_total == 0) m_done_pend = 1'b1;
                else              m_busy      = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [63:0] sh4(input int d0, input int d1, input int d2, input int d3);
        return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    endfunction

    function automatic logic [127:0] st4(input int s0, input int s1, input int s2, input int s3);
        return {32'(s3), 32'(s2), 32'(s1), 32'(s0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_off.delete();
        acc_nth.delete();
        last_nth.delete();
        done_cnt = 0;
    endtask

    task automatic start(input logic [63:0] shape, input logic [127:0] strides, input logic [31:0] base);
        int budget;
        budget = 0;
        while (!bus.cfg_ready && budget < 200) begin
            step();
            budget++;
        end
        if (budget >= 200) check("cfg_ready_timeout", 64'd0, 64'd1);
        bus.cfg_shape   = shape;
        bus.cfg_strides = strides;
        bus.cfg_base    = base;
        bus.cfg_valid   = 1'b1;
        step();
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic wait_walk(input int budget);
        int n;
        n = 0;
        while ((m_busy || m_done_pend) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("walk_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic check_offsets(input string name, input logic [31:0] exp [], input int last_at);
        check({name, "_count"}, 64'(acc_off.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < acc_off.size()) check({name, "_off"}, 64'(acc_off[i]), 64'(exp[i]));
        end
        check({name, "_last_cnt"}, 64'(last_nth.size()), 64'd1);
        if (last_nth.size() > 0) check({name, "_last_nth"}, 64'(last_nth[0]), 64'(last_at));
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        logic [31:0] exp_a [];
        int unsigned total;
        int budget;
        bus.cfg_valid   = 1'b0;
        bus.cfg_shape   = '0;
        bus.cfg_strides = '0;
        bus.cfg_base    = '0;
        bus.abort       = 1'b0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_offset", 64'(bus.out_offset), 64'd0);
        check("rst_index", bus.out_index, 64'd0);
        check("rst_nth", 64'(bus.out_nth), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);

        // abort while idle must do nothing
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_abort_done", 64'(bus.done), 64'd0);

        clear_logs();
        start(sh4(1, 1, 2, 3), st4(0, 0, 3, 1), 32'd0);
        wait_walk(100);
        exp_a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        check_offsets("row_major", exp_a, 5);

        clear_logs();
        start(sh4(1, 1, 2, 3), st4(0, 0, 1, 2), 32'd100);
        wait_walk(100);
        exp_a = '{32'd100, 32'd102, 32'd104, 32'd101, 32'd103, 32'd105};
        check_offsets("transposed", exp_a, 5);

        clear_logs();
        start(sh4(1, 1, 1, 4), st4(0, 0, 0, -1), 32'd3);
        wait_walk(100);
        exp_a = '{32'd3, 32'd2, 32'd1, 32'd0};
        check_offsets("neg_stride", exp_a, 3);

        clear_logs();
        start(sh4(1, 1, 1, 1), st4(5, 6, 7, 8), 32'd42);
        wait_walk(100);
        exp_a = '{32'd42};
        check_offsets("single", exp_a, 0);

        clear_logs();
        start(sh4(1, 1, 3, 0), st4(0, 0, 1, 1), 32'd7);
        wait_walk(100);
        check("zero_acc", 64'(acc_off.size()), 64'd0);
        check("zero_done_cnt", 64'(done_cnt), 64'd1);
        check("zero_cfg_ready", 64'(bus.cfg_ready), 64'd1);

        clear_logs();
        rand_ready = 1'b1;
        start(sh4(1, 2, 2, 2), st4(0, int'($urandom_range(0, 40)) - 20,
                                   int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20),
              $urandom);
        wait_walk(1000);
        check("stall_count", 64'(acc_nth.size()), 64'd8);
        for (int i = 0; i < acc_nth.size(); i++) check("stall_order", 64'(acc_nth[i]), 64'(i));
        check("stall_done_cnt", 64'(done_cnt), 64'd1);
        rand_ready = 1'b0;

        clear_logs();
        start(sh4(1, 1, 2, 3), st4(0, 0, 3, 1), 32'd0);
        budget = 0;
        while (!(bus.out_valid && bus.out_nth == 32'd2) && budget < 50) begin
            step();
            budget++;
        end
        if (budget >= 50) check("abort_wait_timeout", 64'd0, 64'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_idle", 64'(bus.cfg_ready), 64'd1);
        wait_walk(100);
        check("abort_acc", 64'(acc_nth.size()), 64'd2);
        check("abort_done_cnt", 64'(done_cnt), 64'd1);
        clear_logs();
        start(sh4(1, 1, 2, 3), st4(0, 0, 3, 1), 32'd0);
        wait_walk(100);
        check("restart_count", 64'(acc_nth.size()), 64'd6);
        if (acc_nth.size() > 0) check("restart_nth0", 64'(acc_nth[0]), 64'd0);

        // random shapes, strides, stalls and occasional aborts
        for (int t = 0; t < 8; t++) begin
            clear_logs();
            rand_ready = 1'b1;
            start(sh4($urandom_range(1, 2), $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4)),
                  st4(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
                      int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100),
                  $urandom);
            total = m_total;
            if (t % 3 == 2) begin
                repeat ($urandom_range(1, 6)) step();
                bus.abort = 1'b1;
                step();
                bus.abort = 1'b0;
            end
            wait_walk(2000);
            if (t % 3 != 2) check("rand_count", 64'(acc_nth.size()), 64'(total));
            check("rand_done_cnt", 64'(done_cnt), 64'd1);
            for (int i = 0; i < acc_nth.size(); i++) check("rand_order", 64'(acc_nth[i]), 64'(i));
        end
        rand_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not terminate");
    end

endmodule
